// File: rtl/jtpopeye_dma_ctrl_if.sv
// Bus/RAM side and object-buffer side signals of the sprite DMA controller.
// master is the controller's view; slave is the surrounding system's view.
interface jtpopeye_dma_ctrl_if;
    logic       VB;
    logic       dma_en;
    logic       busak_n;
    logic [7:0] DD_DMA;
    logic       busrq_n;
    logic [9:0] AD_DMA;
    logic       dma_cs;
    logic       obj_we;
    logic [9:0] obj_addr;
    logic [7:0] obj_din;
    logic       busy;
    logic       done;

    modport master (
        input  VB, dma_en, busak_n, DD_DMA,
        output busrq_n, AD_DMA, dma_cs, obj_we, obj_addr, obj_din, busy, done
    );

    modport slave (
        output VB, dma_en, busak_n, DD_DMA,
        input  busrq_n, AD_DMA, dma_cs, obj_we, obj_addr, obj_din, busy, done
    );
endinterface

// File: rtl/jtpopeye_dma_ctrl.sv
// Per-frame sprite DMA: on VB rise, takes the Z80 bus and copies LEN bytes of
// main RAM into the object buffer, one byte per cpu_cen.
module jtpopeye_dma_ctrl #(
    parameter int unsigned LEN = 768
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cpu_cen,
    jtpopeye_dma_ctrl_if.master   bus
);

    typedef enum logic [1:0] {StIdle, StReq, StXfer, StRelease} state_e;

    localparam logic [10:0] LenVal = 11'(LEN);

    state_e      state_q, state_d;
    logic        busrq_n_q, busrq_n_d;
    logic [9:0]  ad_q, ad_d;
    logic        dma_cs_q, dma_cs_d;
    logic        obj_we_q, obj_we_d;
    logic [9:0]  obj_addr_q, obj_addr_d;
    logic [7:0]  obj_din_q, obj_din_d;
    logic        done_q, done_d;
    logic        pending_q, pending_d;
    logic        vb_l_q;
    logic [10:0] cnt_q, cnt_d;
    logic [10:0] cnt_inc;
    logic        vb_rise;

    assign vb_rise = bus.VB & ~vb_l_q;
    assign cnt_inc = cnt_q + 11'd1;

    always_comb begin
        state_d    = state_q;
        busrq_n_d  = busrq_n_q;
        ad_d       = ad_q;
        dma_cs_d   = dma_cs_q;
        obj_we_d   = 1'b0;
        obj_addr_d = obj_addr_q;
        obj_din_d  = obj_din_q;
        done_d     = 1'b0;
        pending_d  = pending_q;
        cnt_d      = cnt_q;

        // Frame request is latched on any clk; a rise while busy is dropped.
        if (vb_rise && bus.dma_en && (state_q == StIdle)) pending_d = 1'b1;

        if (cpu_cen) begin
            unique case (state_q)
                StIdle: begin
                    if (pending_q) begin
                        state_d   = StReq;
                        busrq_n_d = 1'b0;
                        pending_d = 1'b0;
                    end
                end
                StReq: begin
                    if (!bus.busak_n) begin
                        state_d  = StXfer;
                        cnt_d    = '0;
                        ad_d     = '0;
                        dma_cs_d = 1'b1;
                    end else if (!bus.VB) begin
                        state_d   = StIdle;
                        busrq_n_d = 1'b1;
                    end
                end
                StXfer: begin
                    if (bus.busak_n) begin
                        // Bus taken away: abandon without writing this byte.
                        state_d   = StIdle;
                        dma_cs_d  = 1'b0;
                        busrq_n_d = 1'b1;
                    end else begin
                        obj_we_d   = 1'b1;
                        obj_addr_d = ad_q;
                        obj_din_d  = bus.DD_DMA;
                        cnt_d      = cnt_inc;
                        if (cnt_inc < LenVal) begin
                            ad_d = cnt_inc[9:0];
                        end else begin
                            dma_cs_d  = 1'b0;
                            busrq_n_d = 1'b1;
                            state_d   = StRelease;
                        end
                    end
                end
                StRelease: begin
                    if (bus.busak_n) begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            busrq_n_q  <= 1'b1;
            ad_q       <= '0;
            dma_cs_q   <= 1'b0;
            obj_we_q   <= 1'b0;
            obj_addr_q <= '0;
            obj_din_q  <= '0;
            done_q     <= 1'b0;
            pending_q  <= 1'b0;
            vb_l_q     <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            busrq_n_q  <= busrq_n_d;
            ad_q       <= ad_d;
            dma_cs_q   <= dma_cs_d;
            obj_we_q   <= obj_we_d;
            obj_addr_q <= obj_addr_d;
            obj_din_q  <= obj_din_d;
            done_q     <= done_d;
            pending_q  <= pending_d;
            vb_l_q     <= bus.VB;
            cnt_q      <= cnt_d;
        end
    end

    assign bus.busrq_n  = busrq_n_q;
    assign bus.AD_DMA   = ad_q;
    assign bus.dma_cs   = dma_cs_q;
    assign bus.obj_we   = obj_we_q;
    assign bus.obj_addr = obj_addr_q;
    assign bus.obj_din  = obj_din_q;
    assign bus.busy     = (state_q != StIdle);
    assign bus.done     = done_q;

endmodule

// File: tb/tb_jtpopeye_dma_ctrl.sv
// Directed bench: three controllers (LEN 4, 8, 1024) with a simple RAM and a
// bus arbiter that grants two cens after each request.
module tb_jtpopeye_dma_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       cpu_cen = 1'b0;
    logic       vb = 1'b0;
    logic [2:0] en = '0;
    logic [2:0] hold = '0;
    int         ccnt = 0;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    always @(negedge clk) begin
        ccnt    <= (ccnt == 2) ? 0 : ccnt + 1;
        cpu_cen <= (ccnt == 2);
    end

    for (genvar g = 0; g < 3; g++) begin : g_dut
        jtpopeye_dma_ctrl_if bus ();

        logic       ack = 1'b1;
        int         dly = 0;
        int         wr_cnt = 0;
        int         done_cnt = 0;
        int         bad_cnt = 0;
        int         busy_cnt = 0;
        int         seq = 0;
        logic [9:0] last_addr = '0;
        logic [7:0] last_din = '0;

        assign bus.VB      = vb;
        assign bus.dma_en  = en[g];
        assign bus.busak_n = ack | hold[g];
        assign bus.DD_DMA  = 8'hA0 + bus.AD_DMA[7:0];

        jtpopeye_dma_ctrl #(
            .LEN ((g == 0) ? 4 : (g == 1) ? 8 : 1024)
        ) u_dut (
            .clk     (clk),
            .rst_n   (rst_n),
            .cpu_cen (cpu_cen),
            .bus     (bus)
        );

        always @(posedge clk) begin
            if (!rst_n) begin
                ack <= 1'b1;
                dly <= 0;
            end else if (cpu_cen) begin
                if (!bus.busrq_n) begin
                    if (dly < 2) dly <= dly + 1;
                    else ack <= 1'b0;
                end else begin
                    dly <= 0;
                    ack <= 1'b1;
                end
            end
        end

        always @(negedge clk) begin
            if (bus.obj_we) begin
                if (bus.obj_addr != 10'(seq) || bus.obj_din != 8'(8'hA0 + bus.obj_addr[7:0]))
                    bad_cnt <= bad_cnt + 1;
                wr_cnt    <= wr_cnt + 1;
                last_addr <= bus.obj_addr;
                last_din  <= bus.obj_din;
            end
            if (!bus.busy) seq <= 0;
            else if (bus.obj_we) seq <= seq + 1;
            if (bus.done) done_cnt <= done_cnt + 1;
            if (bus.busy) busy_cnt <= busy_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // k: 0 writes, 1 done pulses
    function automatic int stat(input int d, input int k);
        case (d)
            0:       return (k == 0) ? g_dut[0].wr_cnt : g_dut[0].done_cnt;
            1:       return (k == 0) ? g_dut[1].wr_cnt : g_dut[1].done_cnt;
            default: return (k == 0) ? g_dut[2].wr_cnt : g_dut[2].done_cnt;
        endcase
    endfunction

    task automatic cens(input int n);
        repeat (n * 3) @(negedge clk);
        #1;
    endtask

    task automatic wait_stat(input string tag, input int d, input int k, input int target,
                             input int budget);
        int i = 0;
        while (stat(d, k) < target && i < budget) begin
            @(negedge clk);
            #1;
            i++;
        end
        check(tag, 32'(stat(d, k) >= target), 32'd1);
    endtask

    task automatic vb_rise();
        vb = 1'b0;
        cens(2);
        vb = 1'b1;
    endtask

    int w0, d0, b0;

    initial begin
        #1 rst_n = 1'b0;
        #1;
        check("rst_busrq_n", 32'(g_dut[0].bus.busrq_n), 32'd1);
        check("rst_dma_cs", 32'(g_dut[0].bus.dma_cs), 32'd0);
        check("rst_busy", 32'(g_dut[0].bus.busy), 32'd0);
        check("rst_obj_we", 32'(g_dut[0].bus.obj_we), 32'd0);
        check("rst_ad", 32'(g_dut[0].bus.AD_DMA), 32'd0);
        check("rst_done", 32'(g_dut[0].bus.done), 32'd0);
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;
        cens(2);

        // Normal copy, LEN=4
        w0 = stat(0, 0); d0 = stat(0, 1);
        en = 3'b001;
        vb_rise();
        wait_stat("norm_wr_reach", 0, 0, w0 + 4, 90);
        check("norm_rq_after_last", 32'(g_dut[0].bus.busrq_n), 32'd1);
        check("norm_cs_after_last", 32'(g_dut[0].bus.dma_cs), 32'd0);
        wait_stat("norm_done_reach", 0, 1, d0 + 1, 60);
        check("norm_writes", 32'(stat(0, 0) - w0), 32'd4);
        check("norm_last_addr", 32'(g_dut[0].last_addr), 32'd3);
        check("norm_last_din", 32'(g_dut[0].last_din), 32'hA3);
        check("norm_bad", 32'(g_dut[0].bad_cnt), 32'd0);
        cens(3);
        check("norm_one_done", 32'(stat(0, 1) - d0), 32'd1);
        check("norm_idle", 32'(g_dut[0].bus.busy), 32'd0);
        vb = 1'b0;
        en = 3'b000;

        // Disabled at VB rise
        w0 = stat(0, 0); b0 = g_dut[0].busy_cnt;
        vb_rise();
        cens(10);
        check("dis_busy", 32'(g_dut[0].busy_cnt - b0), 32'd0);
        check("dis_writes", 32'(stat(0, 0) - w0), 32'd0);
        check("dis_rq", 32'(g_dut[0].bus.busrq_n), 32'd1);
        vb = 1'b0;

        // No grant, blanking ends in REQ
        w0 = stat(0, 0); d0 = stat(0, 1);
        hold = 3'b001; en = 3'b001;
        vb_rise();
        for (int i = 0; i < 30 && g_dut[0].bus.busrq_n; i++) begin
            @(negedge clk);
            #1;
        end
        check("nogr_req", 32'(g_dut[0].bus.busrq_n), 32'd0);
        vb = 1'b0;
        cens(2);
        check("nogr_rq_back", 32'(g_dut[0].bus.busrq_n), 32'd1);
        check("nogr_idle", 32'(g_dut[0].bus.busy), 32'd0);
        check("nogr_writes", 32'(stat(0, 0) - w0), 32'd0);
        check("nogr_done", 32'(stat(0, 1) - d0), 32'd0);
        en = 3'b000;
        cens(2);
        hold = 3'b000;

        // Bus lost after third byte, LEN=8
        w0 = stat(1, 0); d0 = stat(1, 1);
        en = 3'b010;
        vb_rise();
        wait_stat("lost_wr_reach", 1, 0, w0 + 3, 90);
        hold[1] = 1'b1;
        cens(3);
        check("lost_writes", 32'(stat(1, 0) - w0), 32'd3);
        check("lost_last_addr", 32'(g_dut[1].last_addr), 32'd2);
        check("lost_cs", 32'(g_dut[1].bus.dma_cs), 32'd0);
        check("lost_rq", 32'(g_dut[1].bus.busrq_n), 32'd1);
        check("lost_idle", 32'(g_dut[1].bus.busy), 32'd0);
        check("lost_done", 32'(stat(1, 1) - d0), 32'd0);
        hold = 3'b000;
        cens(2);
        w0 = stat(1, 0); d0 = stat(1, 1);
        vb_rise();
        wait_stat("retry_done_reach", 1, 1, d0 + 1, 150);
        check("retry_writes", 32'(stat(1, 0) - w0), 32'd8);
        check("retry_last_addr", 32'(g_dut[1].last_addr), 32'd7);
        check("retry_bad", 32'(g_dut[1].bad_cnt), 32'd0);
        vb = 1'b0;
        en = 3'b000;

        // Full size with a second VB rise during XFER
        w0 = stat(2, 0); d0 = stat(2, 1);
        en = 3'b100;
        vb_rise();
        wait_stat("full_wr_reach", 2, 0, w0 + 10, 90);
        vb = 1'b0;
        cens(2);
        vb = 1'b1;
        wait_stat("full_done_reach", 2, 1, d0 + 1, 4000);
        check("full_writes", 32'(stat(2, 0) - w0), 32'd1024);
        check("full_last_addr", 32'(g_dut[2].last_addr), 32'd1023);
        check("full_last_din", 32'(g_dut[2].last_din), 32'h9F);
        check("full_bad", 32'(g_dut[2].bad_cnt), 32'd0);
        cens(10);
        check("full_one_done", 32'(stat(2, 1) - d0), 32'd1);
        check("full_idle", 32'(g_dut[2].bus.busy), 32'd0);
        check("full_rq", 32'(g_dut[2].bus.busrq_n), 32'd1);

        // Asynchronous reset mid-transfer at byte 100
        w0 = stat(2, 0);
        vb_rise();
        wait_stat("arst_wr_reach", 2, 0, w0 + 100, 600);
        check("arst_pre_cs", 32'(g_dut[2].bus.dma_cs), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("arst_rq", 32'(g_dut[2].bus.busrq_n), 32'd1);
        check("arst_cs", 32'(g_dut[2].bus.dma_cs), 32'd0);
        check("arst_busy", 32'(g_dut[2].bus.busy), 32'd0);
        check("arst_ad", 32'(g_dut[2].bus.AD_DMA), 32'd0);
        check("arst_obj_addr", 32'(g_dut[2].bus.obj_addr), 32'd0);
        check("arst_obj_din", 32'(g_dut[2].bus.obj_din), 32'd0);
        check("arst_obj_we", 32'(g_dut[2].bus.obj_we), 32'd0);
        en = 3'b000;
        @(negedge clk);
        #1 rst_n = 1'b1;
        cens(3);
        check("arst_post_idle", 32'(g_dut[2].bus.busy), 32'd0);
        vb = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/jtpopeye_dma_ctrl.md
Name: jtpopeye_dma_ctrl

Overview:
- Sequences the sprite DMA that copies object attribute bytes from main-CPU RAM into the video object buffer once per frame.
- Starts on the rising edge of VB, requests the Z80 bus (busrq_n/busak_n) and streams LEN bytes at one byte per cpu_cen.
- Drives the AD_DMA/dma_cs read path into main RAM and a write port into the object buffer, then releases the bus.
- Sits between jtpopeye_main (bus and RAM side) and the object-buffer logic in the video section.

Parameters:
LEN, 768, bytes copied per frame; legal range 1..1024.

Ports:
clk  in  1  system clock, 20 MHz
rst_n  in  1  reset, asynchronous, active-low
cpu_cen  in  1  CPU clock enable; all sequencing advances only on clk cycles where cpu_cen=1
VB  in  1  vertical blanking
dma_en  in  1  DMA enable (INITEO); sampled at the VB rising edge
busak_n  in  1  Z80 bus acknowledge, active-low
DD_DMA  in  8  main RAM read data for the address presented at the previous cpu_cen
busrq_n  out  1  Z80 bus request, active-low
AD_DMA  out  10  main RAM read address
dma_cs  out  1  main RAM DMA read select
obj_we  out  1  object buffer write strobe, one clk wide
obj_addr  out  10  object buffer write address
obj_din  out  8  object buffer write data
busy  out  1  high in every state except IDLE
done  out  1  one-clk pulse when a transfer completes normally

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; busrq_n=1; AD_DMA=0; dma_cs=0; obj_we=0; obj_addr=0; obj_din=0; busy=0; done=0; pending=0; vb_l=0.
- Edge detection: vb_l <= VB on every clk (not gated by cen); vb_rise = VB & ~vb_l.
- pending is set when vb_rise=1, dma_en=1 and state=IDLE. A vb_rise while busy is ignored.
- pending is cleared on entry to REQ.
- obj_we and done are deasserted on every clk unless explicitly pulsed below.
- States (transitions only on cpu_cen=1):
  - IDLE: if pending, go to REQ and set busrq_n=0.
  - REQ:
    - If busak_n=0: go to XFER, cnt=0, AD_DMA=0, dma_cs=1.
    - Else if VB=0 (blanking ended before grant): go to IDLE, busrq_n=1, no done.
  - XFER, at each cpu_cen:
    - Write: obj_we=1, obj_addr=AD_DMA, obj_din=DD_DMA.
    - Then cnt=cnt+1 (11-bit, no wrap).
    - If cnt+1 < LEN: AD_DMA=cnt+1.
    - Else: dma_cs=0, busrq_n=1, go to RELEASE.
  - RELEASE: when busak_n=1, go to IDLE and pulse done for one clk.
- Throughput and latency:
  - One byte per cpu_cen.
  - First write occurs one cpu_cen after the grant is sampled.
  - Total is LEN cpu_cen periods in XFER.
- Bus lost mid-transfer: busak_n=1 seen in XFER on a cpu_cen aborts the transfer.
  - That cen's write is suppressed.
  - dma_cs=0, busrq_n=1, go to IDLE, no done.
  - obj_addr/obj_din hold their last values.
- VB falling during XFER does not abort; the transfer runs to completion.
- dma_en deasserted mid-transfer has no effect until the next frame.
- Outputs hold their values between cpu_cen pulses, except the obj_we and done pulses.
- AD_DMA keeps its last value in IDLE.
- Reset mid-transfer returns to the reset values immediately; busrq_n goes high asynchronously.

Test Plan:
- Normal copy:
  - Stimulus: LEN=4, dma_en=1, VB rise, busak_n low 2 cens after busrq_n falls, RAM[i]=8'hA0+i.
  - Required: four obj_we pulses writing addr 0..3 with data A0..A3; busrq_n high after the 4th write; one done pulse after busak_n returns high.
- Disabled: dma_en=0 at VB rise -> busrq_n stays 1, no obj_we, busy=0 for the whole frame.
- No grant: busak_n held 1 and VB falls while in REQ -> busrq_n returns to 1 on the next cen, zero writes, no done, state IDLE.
- Bus lost:
  - Stimulus: LEN=8, busak_n rises after the 3rd write.
  - Required: exactly 3 writes (addr 0..2), dma_cs=0, busrq_n=1, no done; next frame's VB rise restarts the transfer from address 0.
- Full size and retrigger:
  - Stimulus: LEN=1024, plus a second VB rise injected during XFER.
  - Required: 1024 writes with addresses 0..1023 and no counter wrap; the second VB rise is ignored; only one done.
- Async reset:
  - Stimulus: rst_n pulsed low during XFER at byte 100.
  - Required: busrq_n=1 and dma_cs=0 immediately, without waiting for clk; all outputs at reset values.
